// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one single-port data memory between the core
// data port (p0) and a loader/DMA port (p1).
//   - round-robin grant, with an optional bounded lock so one owner can burst
//   - reads return one cycle after the grant on pN_rvalid/pN_rdata (registered)
//   - writes pass straight through to the memory with their byte enables
// Ports:
//   clock, reset_n              clock, async active-low reset
//   pN_req/lock/wren/byteena/   request side (N=0,1), fields held until pN_gnt
//   address/wdata
//   pN_gnt                      combinational grant; transfer at edge with req&gnt
//   pN_rvalid, pN_rdata         registered read response
//   mem_address/wren/byteena/   memory request bus, all zero when idle/in reset
//   data, mem_q                 mem_q is a combinational read of mem_address
module data_memory_arbiter #(
  parameter int unsigned ADDR_BITS = 30,
  parameter int unsigned MAX_LOCK  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 p0_req,
  input  logic                 p0_lock,
  input  logic                 p0_wren,
  input  logic [3:0]           p0_byteena,
  input  logic [ADDR_BITS-1:0] p0_address,
  input  logic [31:0]          p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [31:0]          p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_lock,
  input  logic                 p1_wren,
  input  logic [3:0]           p1_byteena,
  input  logic [ADDR_BITS-1:0] p1_address,
  input  logic [31:0]          p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [31:0]          p1_rdata,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_wren,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_data,
  input  logic [31:0]          mem_q
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;       // port granted most recently; tie goes to the other
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  // State register and registered read return.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      p0_rvalid  <= 1'b0;
      p0_rdata   <= '0;
      p1_rvalid  <= 1'b0;
      p1_rdata   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      p0_rvalid  <= p0_gnt && !p0_wren;
      p1_rvalid  <= p1_gnt && !p1_wren;
      if (p0_gnt && !p0_wren) p0_rdata <= mem_q;
      if (p1_gnt && !p1_wren) p1_rdata <= mem_q;
    end
  end

  // Next state, grant selection and memory mux.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    lock_cnt_d  = lock_cnt_q;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    mem_address = '0;
    mem_wren    = 1'b0;
    mem_byteena = '0;
    mem_data    = '0;

    if (state_q == LOCK0 && p0_req && p0_lock) begin
      p0_gnt = 1'b1;
      if (lock_cnt_q == CNT_LAST) begin
        state_d    = ARB;
        lock_cnt_d = '0;
        last_d     = 1'b0;
      end else begin
        lock_cnt_d = lock_cnt_q + CNT_ONE;
      end
    end else if (state_q == LOCK1 && p1_req && p1_lock) begin
      p1_gnt = 1'b1;
      if (lock_cnt_q == CNT_LAST) begin
        state_d    = ARB;
        lock_cnt_d = '0;
        last_d     = 1'b1;
      end else begin
        lock_cnt_d = lock_cnt_q + CNT_ONE;
      end
    end else begin
      // Open arbitration; an owner that let go of its lock falls through here too.
      state_d    = ARB;
      lock_cnt_d = '0;
      if (p0_req && (!p1_req || last_q)) begin
        p0_gnt = 1'b1;
        last_d = 1'b0;
        if (p0_lock) begin
          state_d    = LOCK0;
          lock_cnt_d = CNT_ONE;
        end
      end else if (p1_req) begin
        p1_gnt = 1'b1;
        last_d = 1'b1;
        if (p1_lock) begin
          state_d    = LOCK1;
          lock_cnt_d = CNT_ONE;
        end
      end
    end

    // Nothing may reach memory while reset is held, even mid-cycle.
    if (!reset_n) begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
    end

    if (p0_gnt) begin
      mem_address = p0_address;
      mem_wren    = p0_wren;
      mem_byteena = p0_byteena;
      mem_data    = p0_wdata;
    end else if (p1_gnt) begin
      mem_address = p1_address;
      mem_wren    = p1_wren;
      mem_byteena = p1_byteena;
      mem_data    = p1_wdata;
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed testbench for data_memory_arbiter with a small byte-enable memory model.
`timescale 1ns/1ps
module tb_data_memory_arbiter;
  localparam int unsigned AW = 30;
  localparam int unsigned ML = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          p0_req, p0_lock, p0_wren, p1_req, p1_lock, p1_wren;
  logic [3:0]    p0_byteena, p1_byteena, mem_byteena;
  logic [AW-1:0] p0_address, p1_address, mem_address;
  logic [31:0]   p0_wdata, p1_wdata, p0_rdata, p1_rdata, mem_data, mem_q;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wren;

  logic [31:0]   tbmem [0:255];
  logic          poke_en;
  logic [7:0]    poke_addr;
  logic [31:0]   poke_data;

  int vectors = 0;
  int errors  = 0;

  always #5 clock = ~clock;

  data_memory_arbiter #(.ADDR_BITS(AW), .MAX_LOCK(ML)) dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_wren(p0_wren), .p0_byteena(p0_byteena),
    .p0_address(p0_address), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_wren(p1_wren), .p1_byteena(p1_byteena),
    .p1_address(p1_address), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_byteena(mem_byteena),
    .mem_data(mem_data), .mem_q(mem_q)
  );

  // Memory model: combinational read, byte-enabled write at the clock edge, plus backdoor preload.
  assign mem_q = tbmem[mem_address[7:0]];
  always @(posedge clock) begin
    if (poke_en) tbmem[poke_addr] <= poke_data;
    else if (mem_wren)
      for (int b = 0; b < 4; b++)
        if (mem_byteena[b]) tbmem[mem_address[7:0]][8*b +: 8] <= mem_data[8*b +: 8];
  end

  task automatic idle_inputs();
    p0_req = 0; p0_lock = 0; p0_wren = 0; p0_byteena = 4'h0; p0_address = '0; p0_wdata = '0;
    p1_req = 0; p1_lock = 0; p1_wren = 0; p1_byteena = 4'h0; p1_address = '0; p1_wdata = '0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clock); poke_en = 1; poke_addr = a; poke_data = d;
    @(negedge clock); poke_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clock); reset_n = 0; #2; reset_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    p0_req = 1; p0_wren = 1; p0_byteena = 4'hF; p0_address = 30'd7; p0_wdata = 32'h55;
    p1_req = 1; p1_address = 30'd9;
    #1;
    vectors++; if (p0_gnt !== 1'b0) begin errors++; $display("FAIL rst_p0_gnt: got %b want 0", p0_gnt); end
    vectors++; if (p1_gnt !== 1'b0) begin errors++; $display("FAIL rst_p1_gnt: got %b want 0", p1_gnt); end
    vectors++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL rst_mem_wren: got %b want 0", mem_wren); end
    vectors++; if (mem_address !== '0) begin errors++; $display("FAIL rst_mem_address: got %h want 0", mem_address); end
    vectors++; if (mem_data !== 32'h0) begin errors++; $display("FAIL rst_mem_data: got %h want 0", mem_data); end
    vectors++; if (mem_byteena !== 4'h0) begin errors++; $display("FAIL rst_mem_byteena: got %h want 0", mem_byteena); end
    vectors++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", p0_rvalid, p1_rvalid); end
    vectors++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", p0_rdata, p1_rdata); end
    @(negedge clock);
    idle_inputs();
    reset_n = 1;
  endtask

  task automatic test_read();
    @(negedge clock);
    p0_req = 1; p0_address = 30'd5;
    #1;
    vectors++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL rd_gnt: got %b%b want 10", p0_gnt, p1_gnt); end
    vectors++; if (mem_address !== 30'd5 || mem_wren !== 1'b0) begin errors++; $display("FAIL rd_mem: got addr %h wren %b want 5/0", mem_address, mem_wren); end
    @(negedge clock);
    idle_inputs();
    #1;
    vectors++; if (p0_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", p0_rvalid); end
    vectors++; if (p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", p0_rdata); end
    vectors++; if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_p1_rvalid: got %b want 0", p1_rvalid); end
    @(negedge clock); #1;
    vectors++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rvalid_drop: got %b want 0", p0_rvalid); end
    vectors++; if (p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata_hold: got %h want deadbeef", p0_rdata); end
  endtask

  task automatic test_alternate();
    logic e0;
    do_reset();
    p0_req = 1; p0_address = 30'd10;
    p1_req = 1; p1_address = 30'd20;
    for (int i = 0; i < 6; i++) begin
      e0 = (i % 2 == 0);
      #1;
      vectors++; if (p0_gnt !== e0 || p1_gnt !== !e0) begin errors++; $display("FAIL alt_gnt[%0d]: got %b%b want %b%b", i, p0_gnt, p1_gnt, e0, !e0); end
      vectors++; if (mem_address !== (e0 ? 30'd10 : 30'd20)) begin errors++; $display("FAIL alt_addr[%0d]: got %0d want %0d", i, mem_address, e0 ? 10 : 20); end
      if (i > 0) begin
        vectors++; if (p0_rvalid !== !e0 || p1_rvalid !== e0) begin errors++; $display("FAIL alt_rvalid[%0d]: got %b%b want %b%b", i, p0_rvalid, p1_rvalid, !e0, e0); end
      end
      @(negedge clock);
    end
    idle_inputs();
    #1;
    vectors++; if (p1_rdata !== 32'h20) begin errors++; $display("FAIL alt_p1_rdata: got %h want 20", p1_rdata); end
  endtask

  task automatic test_lock_burst();
    logic [5:0] exp1;
    exp1 = 6'b101111;  // bit i: p1 granted in cycle i
    do_reset();
    p1_req = 1; p1_lock = 1; p1_address = 30'd30;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin p0_req = 1; p0_address = 30'd31; end
      #1;
      vectors++; if (p1_gnt !== exp1[i] || p0_gnt !== (i >= 1 && !exp1[i])) begin errors++; $display("FAIL lock_gnt[%0d]: got %b%b want %b%b", i, p0_gnt, p1_gnt, !exp1[i], exp1[i]); end
      @(negedge clock);
    end
    idle_inputs();
  endtask

  task automatic test_byteena_write();
    p0_req = 1; p0_wren = 1; p0_byteena = 4'b0101; p0_address = 30'd2; p0_wdata = 32'h11223344;
    #1;
    vectors++; if (p0_gnt !== 1'b1 || mem_wren !== 1'b1) begin errors++; $display("FAIL wr_gnt: got gnt %b wren %b want 1/1", p0_gnt, mem_wren); end
    vectors++; if (mem_byteena !== 4'b0101 || mem_data !== 32'h11223344) begin errors++; $display("FAIL wr_bus: got be %b data %h want 0101/11223344", mem_byteena, mem_data); end
    @(negedge clock);
    vectors++; if (tbmem[2] !== 32'hAA22AA44) begin errors++; $display("FAIL wr_mem: got %h want aa22aa44", tbmem[2]); end
    vectors++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0", p0_rvalid); end
    p0_wren = 0;
    @(negedge clock);
    vectors++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hAA22AA44) begin errors++; $display("FAIL wr_readback: got %b/%h want 1/aa22aa44", p0_rvalid, p0_rdata); end
    p0_wren = 1; p0_byteena = 4'h0; p0_wdata = 32'hFFFFFFFF;
    @(negedge clock);
    vectors++; if (tbmem[2] !== 32'hAA22AA44) begin errors++; $display("FAIL wr_be0_noop: got %h want aa22aa44", tbmem[2]); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    p1_req = 1; p1_wren = 1; p1_byteena = 4'hF; p1_address = 30'd9; p1_wdata = 32'hCAFEF00D;
    @(negedge clock);
    idle_inputs();
    p0_req = 1; p0_address = 30'd9;
    #1;
    vectors++; if (p0_gnt !== 1'b1 || mem_address !== 30'd9) begin errors++; $display("FAIL b2b_gnt: got %b addr %0d want 1/9", p0_gnt, mem_address); end
    @(negedge clock);
    p0_address = 30'd5;
    #1;
    vectors++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_raw: got %b/%h want 1/cafef00d", p0_rvalid, p0_rdata); end
    @(negedge clock);
    idle_inputs();
    #1;
    vectors++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_second: got %b/%h want 1/deadbeef", p0_rvalid, p0_rdata); end
    @(negedge clock); #1;
    vectors++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_idle: got %b/%h want 0/deadbeef", p0_rvalid, p0_rdata); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clock);
    p1_req = 1; p1_address = 30'd5;
    @(negedge clock);
    idle_inputs();
    p0_req = 1; p0_wren = 1; p0_byteena = 4'hF; p0_address = 30'd7; p0_wdata = 32'h12345678;
    #1;
    vectors++; if (mem_wren !== 1'b1 || p1_rvalid !== 1'b1) begin errors++; $display("FAIL mid_pre: got wren %b rvalid %b want 1/1", mem_wren, p1_rvalid); end
    #1; reset_n = 0; #1;
    vectors++; if (mem_wren !== 1'b0 || p0_gnt !== 1'b0 || mem_address !== '0) begin errors++; $display("FAIL mid_bus: got wren %b gnt %b addr %h want 0/0/0", mem_wren, p0_gnt, mem_address); end
    vectors++; if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid: got %b want 0", p1_rvalid); end
    @(negedge clock);
    vectors++; if (tbmem[7] !== 32'h0) begin errors++; $display("FAIL mid_mem: got %h want 0", tbmem[7]); end
    idle_inputs();
    reset_n = 1;
    p0_req = 1; p0_address = 30'd10;
    p1_req = 1; p1_address = 30'd20;
    #1;
    vectors++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL mid_arb: got %b%b want 10", p0_gnt, p1_gnt); end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_lock_drop();
    do_reset();
    p0_req = 1; p0_lock = 1; p0_address = 30'd40;
    #1;
    vectors++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL drop_first: got %b want 1", p0_gnt); end
    @(negedge clock);
    p1_req = 1; p1_address = 30'd41;
    #1;
    vectors++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL drop_held: got %b%b want 10", p0_gnt, p1_gnt); end
    @(negedge clock);
    p0_lock = 0;
    #1;
    vectors++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b1) begin errors++; $display("FAIL drop_switch: got %b%b want 01", p0_gnt, p1_gnt); end
    @(negedge clock);
    #1;
    vectors++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("FAIL drop_arb: got %b%b want 10", p0_gnt, p1_gnt); end
    @(negedge clock);
    idle_inputs();
  endtask

  initial begin
    reset_n = 0;
    poke_en = 0; poke_addr = '0; poke_data = '0;
    idle_inputs();
    poke(8'd5,  32'hDEADBEEF);
    poke(8'd2,  32'hAAAAAAAA);
    poke(8'd7,  32'h00000000);
    poke(8'd9,  32'h00000000);
    poke(8'd10, 32'h00000010);
    poke(8'd20, 32'h00000020);
    poke(8'd30, 32'h00000030);
    poke(8'd31, 32'h00000031);
    poke(8'd40, 32'h00000040);
    poke(8'd41, 32'h00000041);
    test_reset();
    test_read();
    test_alternate();
    test_lock_burst();
    test_byteena_write();
    test_back_to_back();
    test_reset_mid_write();
    test_lock_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
